// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the two-port RAM arbiter
//
// Purpose: state encoding, requester count and the latched command record
//          used by ram_arbiter and ram_arb_picker.
// Address width comes from RAM_ADDRESS_BITWIDTH in define.sv.
`ifndef RAM_ADDRESS_BITWIDTH
`include "define.sv"
`endif

package ram_arbiter_pkg;

  localparam int ADDR_W  = `RAM_ADDRESS_BITWIDTH;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Command captured at acceptance; the RAM side is driven only from this.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/define.sv
// rtl/define.sv - global RAM geometry shared by the arbiter package
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 8
`endif

// File: rtl/ram_arb_picker.sv
// rtl/ram_arb_picker.sv - combinational winner selection for the RAM arbiter
//
// Purpose: turns the requester valids into a one-hot grant.
// Ports:
//   valid_i      in  NUM_REQ  per-requester command present
//   last_grant_i in  1        index of the most recently accepted requester
//   grant_o      out NUM_REQ  one-hot grant (all zero when nothing is valid)
// Parameter RR_EN: 1 = alternate on ties using last_grant_i,
//                  0 = requester 0 wins ties and last_grant_i is ignored.
module ram_arb_picker
  import ram_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic tie;

  assign tie = valid_i[0] & valid_i[1];

  always_comb begin
    grant_o = '0;
    if (tie) begin
      // On a tie the round-robin variant favours whoever did not win last.
      if (RR_EN && (last_grant_i == 1'b0)) begin
        grant_o = 2'b10;
      end else begin
        grant_o = 2'b01;
      end
    end else begin
      // Zero or one requester: the valid vector already is the grant.
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-RAM arbiter with IDLE/ACCESS/DONE sequencing
//
// Purpose: accepts one command at a time from two requesters, performs the
//          RAM read or write, then pulses a per-requester completion.
// Configuration: define RAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
//                otherwise requester 0 has fixed priority.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   reqP_valid/we/addr/wdata    requester P command (P = 0, 1)
//   reqP_ready                  command accepted this cycle (IDLE only)
//   reqP_resp_valid             one-cycle completion pulse
//   reqP_rdata                  last read result for requester P
//   ram_read_address/ram_read_data/ram_read_ready    RAM read port
//   ram_write_address/ram_write_data/ram_write_enable RAM write port
//   busy                        high whenever the FSM is not IDLE
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_resp_valid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_resp_valid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic              ram_write_enable,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  input  logic              ram_read_ready,

  output logic              busy
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              id_q, id_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [NUM_REQ-1:0] valids;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready_vec;
  logic [NUM_REQ-1:0] resp_vec;
  logic               wen;

  assign valids = {req1_valid, req0_valid};

  ram_arb_picker #(
    .RR_EN (RR_EN)
  ) u_picker (
    .valid_i      (valids),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ready_vec    = '0;
    resp_vec     = '0;
    wen          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|valids) begin
          ready_vec    = grant;
          id_d         = grant[1];
          last_grant_d = grant[1];
          if (grant[1]) begin
            cmd_d.we    = req1_we;
            cmd_d.addr  = req1_addr;
            cmd_d.wdata = req1_wdata;
          end else begin
            cmd_d.we    = req0_we;
            cmd_d.addr  = req0_addr;
            cmd_d.wdata = req0_wdata;
          end
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cmd_q.we) begin
          wen     = 1'b1;
          state_d = ST_DONE;
        end else if (ram_read_ready) begin
          if (id_q) begin
            rdata1_d = ram_read_data;
          end else begin
            rdata0_d = ram_read_data;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        resp_vec[id_q] = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset aborts combinationally too: no accept, write or completion
    // may leak out during the cycle in which reset is sampled.
    if (reset) begin
      ready_vec = '0;
      resp_vec  = '0;
      wen       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign req0_ready        = ready_vec[0];
  assign req1_ready        = ready_vec[1];
  assign req0_resp_valid   = resp_vec[0];
  assign req1_resp_valid   = resp_vec[1];
  assign req0_rdata        = rdata0_q;
  assign req1_rdata        = rdata1_q;

  // Both RAM addresses follow the latch unconditionally; addr[0] is not
  // stripped because word selection belongs to the RAM.
  assign ram_read_address  = cmd_q.addr;
  assign ram_write_address = cmd_q.addr;
  assign ram_write_data    = cmd_q.wdata;
  assign ram_write_enable  = wen;

  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_we, req1_valid, req1_we;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [31:0]       req0_wdata, req1_wdata;
  logic              req0_ready, req0_resp_valid, req1_ready, req1_resp_valid;
  logic [31:0]       req0_rdata, req1_rdata;
  logic [ADDR_W-1:0] ram_read_address, ram_write_address;
  logic              ram_write_enable;
  logic [31:0]       ram_write_data, ram_read_data;
  logic              ram_read_ready;
  logic              busy;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .req0_valid        (req0_valid),
    .req0_we           (req0_we),
    .req0_addr         (req0_addr),
    .req0_wdata        (req0_wdata),
    .req0_ready        (req0_ready),
    .req0_resp_valid   (req0_resp_valid),
    .req0_rdata        (req0_rdata),
    .req1_valid        (req1_valid),
    .req1_we           (req1_we),
    .req1_addr         (req1_addr),
    .req1_wdata        (req1_wdata),
    .req1_ready        (req1_ready),
    .req1_resp_valid   (req1_resp_valid),
    .req1_rdata        (req1_rdata),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write_enable  (ram_write_enable),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data),
    .ram_read_ready    (ram_read_ready),
    .busy              (busy)
  );

  // RAM model written only by the DUT; shadow is the bench's own expectation.
  logic [31:0] ram_mem [0:(1<<ADDR_W)-1];
  logic [31:0] shadow  [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (ram_write_enable) ram_mem[ram_write_address] <= ram_write_data;
  assign ram_read_data = ram_mem[ram_read_address];

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit                p;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    int                rr_delay;
    logic [31:0]       exp_rdata;
  } vec_t;

  typedef struct {
    bit          p;
    bit          we;
    logic [31:0] rdata;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] exp_rd [2];
  vec_t        vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_ready(input bit p);
    return p ? req1_ready : req0_ready;
  endfunction

  function automatic logic get_resp(input bit p);
    return p ? req1_resp_valid : req0_resp_valid;
  endfunction

  function automatic logic [31:0] get_rdata(input bit p);
    return p ? req1_rdata : req0_rdata;
  endfunction

  task automatic set_req(input bit p, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
    if (p) begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end
  endtask

  // Pop the scoreboard for a completion seen on requester p and check rdata.
  task automatic take_resp(input bit p);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: resp_valid%0d with nothing outstanding", p);
    end else begin
      e = sb_q.pop_front();
      chk("resp_id", {31'd0, p}, {31'd0, e.p});
      if (!e.we) exp_rd[e.p] = e.rdata;
    end
    chk("rdata0", req0_rdata, exp_rd[0]);
    chk("rdata1", req1_rdata, exp_rd[1]);
  endtask

  task automatic do_cmd(input vec_t v);
    logic got;
    @(negedge clk);
    set_req(v.p, 1'b1, v.we, v.addr, v.wdata);
    ram_read_ready = (v.rr_delay == 0);
    #1;
    got = get_ready(v.p);
    chk("ready", got, 1);
    chk("ready_other", get_ready(!v.p), 0);
    chk("busy_idle", busy, 0);
    if (got) sb_q.push_back('{v.p, v.we, v.we ? exp_rd[v.p] : v.exp_rdata});
    if (v.we) shadow[v.addr] = v.wdata;
    // ACCESS: requester drops valid and scribbles its command lines.
    @(negedge clk);
    set_req(v.p, 1'b0, ~v.we, ~v.addr, ~v.wdata);
    #1;
    chk("busy_access", busy, 1);
    chk("ready_access", {31'd0, req0_ready | req1_ready}, 0);
    if (v.we) begin
      chk("wen", ram_write_enable, 1);
      chk("waddr", ram_write_address, v.addr);
      chk("wdata", ram_write_data, v.wdata);
    end else begin
      chk("wen_read", ram_write_enable, 0);
      chk("raddr", ram_read_address, v.addr);
      for (int i = 0; i < v.rr_delay; i++) begin
        chk("resp_early", {31'd0, req0_resp_valid | req1_resp_valid}, 0);
        chk("busy_wait", busy, 1);
        @(negedge clk);
        #1;
      end
      ram_read_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("resp_valid", get_resp(v.p), 1);
    chk("resp_other", get_resp(!v.p), 0);
    if (get_resp(v.p)) take_resp(v.p);
    chk("wen_done", ram_write_enable, 0);
    chk("busy_done", busy, 1);
    @(negedge clk);
    #1;
    chk("busy_back", busy, 0);
    chk("resp_gone", {31'd0, req0_resp_valid | req1_resp_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  grants [4];
    logic [1:0]  exp_g  [4];
    int          n;
    vec_t        v;

    vecs[0] = '{0, 1, 'h10, 32'hDEADBEEF, 0, 32'h0};
    vecs[1] = '{1, 0, 'h10, 32'h0,        0, 32'hDEADBEEF};
    vecs[2] = '{1, 1, 'h11, 32'h12345678, 0, 32'h0};
    vecs[3] = '{0, 0, 'h11, 32'h0,        3, 32'h12345678};
    vecs[4] = '{1, 1, 'h10, 32'hCAFEF00D, 0, 32'h0};
    vecs[5] = '{0, 0, 'h10, 32'h0,        1, 32'hCAFEF00D};
    vecs[6] = '{1, 0, 'h11, 32'h0,        2, 32'h12345678};
    vecs[7] = '{0, 1, 'h30, 32'h11112222, 0, 32'h0};

`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_g = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_g = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

    exp_rd[0] = '0;
    exp_rd[1] = '0;
    reset = 1'b1;
    ram_read_ready = 1'b1;
    set_req(0, 1'b1, 1'b1, 'h5, 32'h5);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // Reset state, with a request held to prove ready stays low.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wen", ram_write_enable, 0);
    chk("rst_resp", {31'd0, req0_resp_valid | req1_resp_valid}, 0);
    chk("rst_rdata0", req0_rdata, 0);
    chk("rst_rdata1", req1_rdata, 0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) do_cmd(vecs[i]);

    // Reset while a write sits in ACCESS: no write, no completion.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 'h30, 32'hAAAA5555);
    #1;
    chk("rstw_ready", req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #1;
    chk("rstw_wen", ram_write_enable, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_wen_after", ram_write_enable, 0);
    chk("rstw_resp", {31'd0, req0_resp_valid | req1_resp_valid}, 0);
    chk("rstw_rdata0", req0_rdata, 0);
    chk("rstw_rdata1", req1_rdata, 0);
    @(negedge clk);
    #1;
    chk("rstw_resp2", {31'd0, req0_resp_valid | req1_resp_valid}, 0);
    chk("rstw_mem", ram_mem['h30], shadow['h30]);
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Both requesters reading continuously.
    n = 0;
    ram_read_ready = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 'h10, '0);
    set_req(1, 1'b1, 1'b0, 'h11, '0);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req0_ready && req1_ready) chk("arb_onehot", 2'b11, 2'b01);
      if ((req0_ready || req1_ready) && n < 4) begin
        grants[n] = {1'b0, req1_ready};
        sb_q.push_back('{req1_ready, 1'b0, req1_ready ? shadow['h11] : shadow['h10]});
        n++;
      end
      if (req0_resp_valid || req1_resp_valid) take_resp(req1_resp_valid);
      if (n == 4 && sb_q.size() == 0) break;
      @(negedge clk);
      if (n == 4) begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    chk("arb_count", n, 4);
    chk("arb_drained", sb_q.size(), 0);
    for (int i = 0; i < n; i++) chk($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);

    // Normal operation resumes after the aborted write.
    @(negedge clk);
    v = '{1, 0, 'h10, 32'h0, 0, 32'hCAFEF00D};
    do_cmd(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
